// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched
// Two requesters share one combinational FP add/sub datapath through this
// sequencer. An accepted request is registered and unpacked onto the dp_*
// outputs. Those outputs are held for EXEC_CYCLES cycles. The datapath result
// is then captured and returned with the requester id and tag.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready            per-requester handshake (N = 0, 1)
//   reqN_op/a/b/tag             per-requester payload: op 0=add 1=sub,
//                               packed single-precision operands, tag
//   dp_opcode, dp_sign/exp/sig  unpacked operands driven to the datapath
//   dp_fp_out, dp_err           datapath result and error code
//   rsp_valid/ready             response handshake
//   rsp_result/err/id/tag       captured result, error, requester index, tag
//   busy                        high whenever the sequencer is not idle
//   done_count                  completed responses, wraps at 2^CNT_W
module fp_addsub_sched #(
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             dp_opcode,
  output logic             dp_sign1,
  output logic [7:0]       dp_exp1,
  output logic [22:0]      dp_sig1,
  output logic             dp_sign2,
  output logic [7:0]       dp_exp2,
  output logic [22:0]      dp_sig2,
  input  logic [31:0]      dp_fp_out,
  input  logic [2:0]       dp_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_err,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The settle counter is 4 bits wide, which covers EXEC_CYCLES up to 15.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             last_grant_q;
  logic             op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;
  logic [31:0]      result_q;
  logic [2:0]       err_q;
  logic [CNT_W-1:0] done_q;

  logic             grant_vld_d;
  logic             grant_id_d;

  // On a tie, grant the requester that did not win last time. last_grant
  // resets to 1, so requester 0 wins the first tie. Ready is suppressed
  // during the reset cycle.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = 1'b0;
      end else if (req1_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld_d && !grant_id_d;
  assign req1_ready = grant_vld_d && grant_id_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op_q         <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      tag_q        <= '0;
      id_q         <= 1'b0;
      result_q     <= 32'd0;
      err_q        <= 3'd0;
      done_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            op_q         <= grant_id_d ? req1_op  : req0_op;
            a_q          <= grant_id_d ? req1_a   : req0_a;
            b_q          <= grant_id_d ? req1_b   : req0_b;
            tag_q        <= grant_id_d ? req1_tag : req0_tag;
            id_q         <= grant_id_d;
            last_grant_q <= grant_id_d;
            cnt_q        <= CNT_INIT;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // Sample the datapath in the last settle cycle, so the result
          // reflects operands that have been stable for EXEC_CYCLES cycles.
          if (cnt_q == 4'd0) begin
            result_q <= dp_fp_out;
            err_q    <= dp_err;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            done_q  <= done_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The operand registers change only on accept, so the datapath inputs and
  // the echoed id/tag stay stable through EXEC and RESP.
  assign dp_opcode  = op_q;
  assign dp_sign1   = a_q[31];
  assign dp_exp1    = a_q[30:23];
  assign dp_sig1    = a_q[22:0];
  assign dp_sign2   = b_q[31];
  assign dp_exp2    = b_q[30:23];
  assign dp_sig2    = b_q[22:0];

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign rsp_id     = id_q;
  assign rsp_tag    = tag_q;
  assign busy       = (state_q != IDLE);
  assign done_count = done_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
module tb_fp_addsub_sched;

  logic        clk;
  logic        rst;
  logic        r0v, r1v, r0op, r1op, e1v, zero_v, rrdy;
  logic [31:0] r0a, r0b, r1a, r1b, fpo;
  logic [3:0]  r0tag, r1tag;
  logic [2:0]  derr;

  // u0: default build
  logic        u0_r0rdy, u0_r1rdy, u0_op, u0_s1, u0_s2, u0_rv, u0_id, u0_busy;
  logic [7:0]  u0_e1, u0_e2;
  logic [22:0] u0_g1, u0_g2;
  logic [31:0] u0_res;
  logic [2:0]  u0_err;
  logic [3:0]  u0_tag;
  logic [15:0] u0_done;
  // u1: EXEC_CYCLES=1 build
  logic        u1_r0rdy, u1_r1rdy, u1_op, u1_s1, u1_s2, u1_rv, u1_id, u1_busy;
  logic [7:0]  u1_e1, u1_e2;
  logic [22:0] u1_g1, u1_g2;
  logic [31:0] u1_res;
  logic [2:0]  u1_err;
  logic [3:0]  u1_tag;
  logic [15:0] u1_done;
  // u2: CNT_W=2 build, driven in lockstep with u0
  logic        u2_r0rdy, u2_r1rdy, u2_op, u2_s1, u2_s2, u2_rv, u2_id, u2_busy;
  logic [7:0]  u2_e1, u2_e2;
  logic [22:0] u2_g1, u2_g2;
  logic [31:0] u2_res;
  logic [2:0]  u2_err;
  logic [3:0]  u2_tag;
  logic [1:0]  u2_done;

  int checks = 0;
  int failures = 0;

  fp_addsub_sched u0 (
    .clk(clk), .reset(rst),
    .req0_valid(r0v), .req0_ready(u0_r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_tag(r0tag),
    .req1_valid(r1v), .req1_ready(u0_r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_tag(r1tag),
    .dp_opcode(u0_op), .dp_sign1(u0_s1), .dp_exp1(u0_e1), .dp_sig1(u0_g1),
    .dp_sign2(u0_s2), .dp_exp2(u0_e2), .dp_sig2(u0_g2),
    .dp_fp_out(fpo), .dp_err(derr),
    .rsp_valid(u0_rv), .rsp_ready(rrdy), .rsp_result(u0_res), .rsp_err(u0_err),
    .rsp_id(u0_id), .rsp_tag(u0_tag), .busy(u0_busy), .done_count(u0_done)
  );

  fp_addsub_sched #(.EXEC_CYCLES(1)) u1 (
    .clk(clk), .reset(rst),
    .req0_valid(e1v), .req0_ready(u1_r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_tag(r0tag),
    .req1_valid(zero_v), .req1_ready(u1_r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_tag(r1tag),
    .dp_opcode(u1_op), .dp_sign1(u1_s1), .dp_exp1(u1_e1), .dp_sig1(u1_g1),
    .dp_sign2(u1_s2), .dp_exp2(u1_e2), .dp_sig2(u1_g2),
    .dp_fp_out(fpo), .dp_err(derr),
    .rsp_valid(u1_rv), .rsp_ready(rrdy), .rsp_result(u1_res), .rsp_err(u1_err),
    .rsp_id(u1_id), .rsp_tag(u1_tag), .busy(u1_busy), .done_count(u1_done)
  );

  fp_addsub_sched #(.CNT_W(2)) u2 (
    .clk(clk), .reset(rst),
    .req0_valid(r0v), .req0_ready(u2_r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_tag(r0tag),
    .req1_valid(r1v), .req1_ready(u2_r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_tag(r1tag),
    .dp_opcode(u2_op), .dp_sign1(u2_s1), .dp_exp1(u2_e1), .dp_sig1(u2_g1),
    .dp_sign2(u2_s2), .dp_exp2(u2_e2), .dp_sig2(u2_g2),
    .dp_fp_out(fpo), .dp_err(derr),
    .rsp_valid(u2_rv), .rsp_ready(rrdy), .rsp_result(u2_res), .rsp_err(u2_err),
    .rsp_id(u2_id), .rsp_tag(u2_tag), .busy(u2_busy), .done_count(u2_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; r0v = 1'b1; r1v = 1'b0; e1v = 1'b0; zero_v = 1'b0;
    r0op = 1'b0; r1op = 1'b0; r0a = 32'd0; r0b = 32'd0; r1a = 32'd0; r1b = 32'd0;
    r0tag = 4'd0; r1tag = 4'd0; fpo = 32'd0; derr = 3'd0; rrdy = 1'b1;

    // Reset cycle: ready held low even with a valid request.
    tick();
    #1;
    chk("rst_ready0", {31'd0, u0_r0rdy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, u0_rv}, 32'd0);
    chk("rst_busy", {31'd0, u0_busy}, 32'd0);
    chk("rst_done", {16'd0, u0_done}, 32'd0);
    chk("rst_dp_exp1", {24'd0, u0_e1}, 32'd0);
    chk("rst_rsp_result", u0_res, 32'd0);

    // Single op: 1.0 + 2.0, tag 5.
    tick();
    rst = 1'b0; r0v = 1'b1; r0a = 32'h3F800000; r0b = 32'h40000000; r0op = 1'b0;
    r0tag = 4'd5; fpo = 32'h40400000; derr = 3'd0; rrdy = 1'b1;
    #1;
    chk("single_ready0_c0", {31'd0, u0_r0rdy}, 32'd1);
    chk("single_ready1_c0", {31'd0, u0_r1rdy}, 32'd0);
    tick();
    r0v = 1'b0;
    #1;
    chk("single_dp_exp1", {24'd0, u0_e1}, 32'h7F);
    chk("single_dp_sig2", {9'd0, u0_g2}, 32'd0);
    chk("single_dp_exp2", {24'd0, u0_e2}, 32'h80);
    chk("single_busy_c1", {31'd0, u0_busy}, 32'd1);
    chk("single_rv_c1", {31'd0, u0_rv}, 32'd0);
    tick();
    #1;
    chk("single_rv_c2", {31'd0, u0_rv}, 32'd0);
    tick();
    #1;
    chk("single_rv_c3", {31'd0, u0_rv}, 32'd1);
    chk("single_result", u0_res, 32'h40400000);
    chk("single_id", {31'd0, u0_id}, 32'd0);
    chk("single_tag", {28'd0, u0_tag}, 32'd5);
    tick();
    #1;
    chk("single_done", {16'd0, u0_done}, 32'd1);
    chk("single_rv_c4", {31'd0, u0_rv}, 32'd0);

    // Tie arbitration after a fresh reset: grants 0,1,0,1 four cycles apart.
    rst = 1'b1;
    tick();
    rst = 1'b0; r0v = 1'b1; r1v = 1'b1; r0tag = 4'h3; r1tag = 4'hC;
    r1a = 32'h40800000; r1b = 32'h3F800000; r1op = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fpo = 32'h40000000 + 32'(k);
      #1;
      chk("tie_ready0", {31'd0, u0_r0rdy}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_ready1", {31'd0, u0_r1rdy}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      #1;
      chk("tie_noready_c1", {30'd0, u0_r0rdy, u0_r1rdy}, 32'd0);
      tick();
      tick();
      #1;
      chk("tie_rv", {31'd0, u0_rv}, 32'd1);
      chk("tie_id", {31'd0, u0_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("tie_tag", {28'd0, u0_tag}, (k % 2 == 1) ? 32'hC : 32'h3);
      chk("tie_result", u0_res, 32'h40000000 + 32'(k));
      tick();
      if (k == 3) begin
        r0v = 1'b0;
        r1v = 1'b0;
      end
      chk("tie_done", {16'd0, u0_done}, 32'(k + 1));
      chk("wrap_done", {30'd0, u2_done}, 32'((k + 1) % 4));
    end

    // Backpressure: req1 op, rsp_ready low for 5 RESP cycles.
    r1v = 1'b1; r1tag = 4'h9; rrdy = 1'b0; fpo = 32'h11111111; derr = 3'b101;
    #1;
    chk("bp_ready1", {31'd0, u0_r1rdy}, 32'd1);
    tick();
    r1v = 1'b0; r0v = 1'b1;
    #1;
    chk("bp_ready0_exec", {31'd0, u0_r0rdy}, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rv", {31'd0, u0_rv}, 32'd1);
      chk("bp_result", u0_res, 32'h11111111);
      chk("bp_err", {29'd0, u0_err}, 32'd5);
      chk("bp_id", {31'd0, u0_id}, 32'd1);
      chk("bp_tag", {28'd0, u0_tag}, 32'h9);
      chk("bp_ready0_stall", {31'd0, u0_r0rdy}, 32'd0);
      fpo = ~fpo;
      derr = ~derr;
      tick();
    end
    rrdy = 1'b1;
    #1;
    chk("bp_rv_release", {31'd0, u0_rv}, 32'd1);
    chk("bp_result_release", u0_res, 32'h11111111);
    tick();
    r0v = 1'b0;
    #1;
    chk("bp_rv_after", {31'd0, u0_rv}, 32'd0);
    chk("bp_done", {16'd0, u0_done}, 32'd5);
    chk("wrap_done_5", {30'd0, u2_done}, 32'd1);

    // Reset in cycle 2 of an op discards it.
    tick();
    r0v = 1'b1; r0tag = 4'd7; r0op = 1'b0; r0a = 32'h3F800000;
    #1;
    chk("rmid_ready0", {31'd0, u0_r0rdy}, 32'd1);
    tick();
    r0v = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rmid_ready_in_rst", {30'd0, u0_r0rdy, u0_r1rdy}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmid_rv", {31'd0, u0_rv}, 32'd0);
    chk("rmid_busy", {31'd0, u0_busy}, 32'd0);
    chk("rmid_dp_exp1", {24'd0, u0_e1}, 32'd0);
    chk("rmid_tag", {28'd0, u0_tag}, 32'd0);
    chk("rmid_done", {16'd0, u0_done}, 32'd0);
    chk("rmid_result", u0_res, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("rmid_no_rsp", {31'd0, u0_rv}, 32'd0);
    end
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("rmid_tie_ready0", {31'd0, u0_r0rdy}, 32'd1);
    chk("rmid_tie_ready1", {31'd0, u0_r1rdy}, 32'd0);
    tick();
    r0v = 1'b0; r1v = 1'b0;

    // EXEC_CYCLES=1 build, subtract.
    r0op = 1'b1; r0a = 32'hC0A00000; r0tag = 4'hA; fpo = 32'h12345678; rrdy = 1'b1;
    e1v = 1'b1;
    #1;
    chk("e1_ready0", {31'd0, u1_r0rdy}, 32'd1);
    tick();
    e1v = 1'b0;
    #1;
    chk("e1_opcode", {31'd0, u1_op}, 32'd1);
    chk("e1_sign1", {31'd0, u1_s1}, 32'd1);
    chk("e1_rv_c1", {31'd0, u1_rv}, 32'd0);
    tick();
    #1;
    chk("e1_rv_c2", {31'd0, u1_rv}, 32'd1);
    chk("e1_result", u1_res, 32'h12345678);
    chk("e1_tag", {28'd0, u1_tag}, 32'hA);
    tick();
    #1;
    chk("e1_done", {16'd0, u1_done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
